// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the systolic array feeder.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    FEED  = 2'd2,
    DRAIN = 2'd3
  } feed_state_t;

  // Number of FEED steps needed for the last product to reach PE(size-1,size-1).
  function automatic int unsigned FEED_LEN(input int unsigned size);
    return 3 * size - 2;
  endfunction

  function automatic int unsigned SEL_W(input int unsigned size);
    return (size > 1) ? $clog2(size) : 1;
  endfunction

endpackage

// File: rtl/skew_select.sv
// One skewed edge lane: presents element [t-lane] of the lane's operand
// vector while that index is in range, zero otherwise.
module skew_select
  import systolic_pkg::*;
#(
  parameter int unsigned size = 3,
  parameter int unsigned n    = 16,
  parameter int unsigned tw   = 3,
  parameter int unsigned lane = 0
) (
  input  logic          en,
  input  logic [tw-1:0] t,
  input  logic [n-1:0]  vec [size],
  output logic [n-1:0]  data
);

  localparam int unsigned SW = SEL_W(size);
  localparam logic [tw-1:0] LO = tw'(lane);
  localparam logic [tw-1:0] HI = tw'(lane + size);

  logic [tw-1:0] k;

  always_comb begin
    data = '0;
    k    = t - LO;
    if (en && (t >= LO) && (t < HI)) begin
      data = vec[k[SW-1:0]];
    end
  end

endmodule

// File: rtl/systolic_feeder.sv
// Operand staging, skewed feed and result drain around a size x size
// systolic array; results leave on a valid/ready stream in row-major order.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned size = 3,
  parameter int unsigned n    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_en,
  input  logic                     ld_sel,
  input  logic [$clog2(size)-1:0]  ld_row,
  input  logic [$clog2(size)-1:0]  ld_col,
  input  logic [n-1:0]             ld_data,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     arr_clr,
  output logic [size-1:0]          r_en,
  output logic [size-1:0]          c_en,
  output logic [n-1:0]             l_x_out [size],
  output logic [n-1:0]             t_w_out [size],
  output logic [$clog2(size)-1:0]  s_row,
  output logic [$clog2(size)-1:0]  s_col,
  input  logic [n-1:0]             b_s_in,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [n-1:0]             res_data,
  output logic [$clog2(size)-1:0]  res_row,
  output logic [$clog2(size)-1:0]  res_col
);

  localparam int unsigned SW = $clog2(size);
  localparam int unsigned TW = $clog2(FEED_LEN(size));
  localparam logic [TW-1:0] LAST_T   = TW'(FEED_LEN(size) - 1);
  localparam logic [SW-1:0] LAST_IDX = SW'(size - 1);

  feed_state_t   state;
  logic [TW-1:0] t;
  logic [SW-1:0] row, col;
  logic [n-1:0]  x_buf [size][size];
  logic [n-1:0]  w_buf [size][size];
  logic          feeding;
  logic          draining;
  logic          ld_in_range;

  assign feeding     = (state == FEED);
  assign draining    = (state == DRAIN);
  assign ld_in_range = (32'(ld_row) < size) && (32'(ld_col) < size);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      t     <= '0;
      row   <= '0;
      col   <= '0;
      done  <= 1'b0;
      for (int unsigned i = 0; i < size; i++) begin
        for (int unsigned j = 0; j < size; j++) begin
          x_buf[i][j] <= '0;
          w_buf[i][j] <= '0;
        end
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          // A write in the start cycle lands before the job reads the buffers.
          if (ld_en && ld_in_range) begin
            if (ld_sel) w_buf[ld_row][ld_col] <= ld_data;
            else        x_buf[ld_row][ld_col] <= ld_data;
          end
          if (start) state <= CLEAR;
        end
        CLEAR: begin
          state <= FEED;
          t     <= '0;
        end
        FEED: begin
          if (t == LAST_T) begin
            state <= DRAIN;
            t     <= '0;
            row   <= '0;
            col   <= '0;
          end else begin
            t <= t + 1'b1;
          end
        end
        DRAIN: begin
          if (res_ready) begin
            if (col == LAST_IDX) begin
              col <= '0;
              if (row == LAST_IDX) begin
                row   <= '0;
                state <= IDLE;
                done  <= 1'b1;
              end else begin
                row <= row + 1'b1;
              end
            end else begin
              col <= col + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign arr_clr   = (state == CLEAR);
  assign r_en      = {size{feeding}};
  assign c_en      = {size{feeding}};
  assign s_row     = row;
  assign s_col     = col;
  assign res_row   = row;
  assign res_col   = col;
  assign res_valid = draining;
  assign res_data  = draining ? b_s_in : '0;

  for (genvar g = 0; g < size; g++) begin : g_lane
    logic [n-1:0] x_vec [size];
    logic [n-1:0] w_vec [size];

    // X lanes walk a buffer row, W lanes walk a buffer column.
    always_comb begin
      for (int unsigned k = 0; k < size; k++) begin
        x_vec[k] = x_buf[g][k];
        w_vec[k] = w_buf[k][g];
      end
    end

    skew_select #(.size(size), .n(n), .tw(TW), .lane(g)) u_x (
      .en   (feeding),
      .t    (t),
      .vec  (x_vec),
      .data (l_x_out[g])
    );

    skew_select #(.size(size), .n(n), .tw(TW), .lane(g)) u_w (
      .en   (feeding),
      .t    (t),
      .vec  (w_vec),
      .data (t_w_out[g])
    );
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: behavioural Q8.8 array model on the edge
// ports, phase-level reference of the feeder, plus directed literal checks.
module tb_systolic_feeder;

  localparam int S = 3;

  logic        clk = 1'b0;
  logic        reset, ld_en, ld_sel, start, res_ready;
  logic [1:0]  ld_row, ld_col;
  logic [15:0] ld_data;
  logic        busy, done, arr_clr, res_valid;
  logic [2:0]  r_en, c_en;
  logic [15:0] l_x_out [S];
  logic [15:0] t_w_out [S];
  logic [1:0]  s_row, s_col, res_row, res_col;
  logic [15:0] b_s_in, res_data;

  always #5 clk = ~clk;

  systolic_feeder #(.size(S), .n(16)) dut (
    .clk(clk), .reset(reset), .ld_en(ld_en), .ld_sel(ld_sel),
    .ld_row(ld_row), .ld_col(ld_col), .ld_data(ld_data), .start(start),
    .busy(busy), .done(done), .arr_clr(arr_clr), .r_en(r_en), .c_en(c_en),
    .l_x_out(l_x_out), .t_w_out(t_w_out), .s_row(s_row), .s_col(s_col),
    .b_s_in(b_s_in), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_row(res_row), .res_col(res_col)
  );

  int checks = 0;
  int passed = 0;
  bit cmp_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  function automatic logic [15:0] mulq(input logic [15:0] a, input logic [15:0] b);
    logic signed [31:0] p;
    p = $signed(a) * $signed(b);
    return p[23:8];
  endfunction

  // Output-stationary array: operands hop one PE per cycle, accumulators clear on reset/arr_clr.
  logic [15:0] ax [S][S];
  logic [15:0] aw [S][S];
  logic [15:0] acc [S][S];

  function automatic logic [15:0] xin(input int i, input int j);
    if (j == 0) return l_x_out[i];
    return ax[i][j-1];
  endfunction

  function automatic logic [15:0] win(input int i, input int j);
    if (i == 0) return t_w_out[j];
    return aw[i-1][j];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < S; i++) begin
      for (int j = 0; j < S; j++) begin
        if (reset || arr_clr) begin
          ax[i][j]  <= '0;
          aw[i][j]  <= '0;
          acc[i][j] <= '0;
        end else if (r_en[i] && c_en[j]) begin
          acc[i][j] <= acc[i][j] + mulq(xin(i, j), win(i, j));
          ax[i][j]  <= xin(i, j);
          aw[i][j]  <= win(i, j);
        end
      end
    end
  end

  assign b_s_in = acc[s_row][s_col];

  // Reference: phase 0 idle, 1 clear, 2 feed (step m_t), 3 drain (linear index m_idx).
  int          m_phase, m_t, m_idx;
  bit          m_done;
  logic [15:0] xm [S][S];
  logic [15:0] wm [S][S];

  function automatic logic [15:0] cexp(input int i, input int j);
    logic [15:0] s;
    s = '0;
    for (int k = 0; k < S; k++) s = s + mulq(xm[i][k], wm[k][j]);
    return s;
  endfunction

  always @(posedge clk) begin
    m_done <= 1'b0;
    if (reset) begin
      m_phase <= 0;
      m_t     <= 0;
      m_idx   <= 0;
      for (int i = 0; i < S; i++)
        for (int j = 0; j < S; j++) begin
          xm[i][j] <= '0;
          wm[i][j] <= '0;
        end
    end else begin
      case (m_phase)
        0: begin
          if (ld_en) begin
            if (ld_sel) wm[ld_row][ld_col] <= ld_data;
            else        xm[ld_row][ld_col] <= ld_data;
          end
          if (start) m_phase <= 1;
        end
        1: begin m_phase <= 2; m_t <= 0; end
        2: begin
          if (m_t == 3 * S - 3) begin m_phase <= 3; m_idx <= 0; end
          else m_t <= m_t + 1;
        end
        default: begin
          if (res_ready) begin
            if (m_idx == S * S - 1) begin m_phase <= 0; m_idx <= 0; m_done <= 1'b1; end
            else m_idx <= m_idx + 1;
          end
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (cmp_on) begin
      logic [15:0] ex, ew;
      int er, ec;
      chk("busy", busy, m_phase != 0);
      chk("done", done, m_done);
      chk("arr_clr", arr_clr, m_phase == 1);
      chk("r_en", r_en, (m_phase == 2) ? 3'b111 : 3'b000);
      chk("c_en", c_en, (m_phase == 2) ? 3'b111 : 3'b000);
      for (int i = 0; i < S; i++) begin
        ex = '0;
        ew = '0;
        if (m_phase == 2 && m_t >= i && m_t - i < S) begin
          ex = xm[i][m_t-i];
          ew = wm[m_t-i][i];
        end
        chk("l_x_out", l_x_out[i], ex);
        chk("t_w_out", t_w_out[i], ew);
      end
      er = (m_phase == 3) ? m_idx / S : 0;
      ec = (m_phase == 3) ? m_idx % S : 0;
      chk("res_valid", res_valid, m_phase == 3);
      chk("s_row", s_row, er);
      chk("s_col", s_col, ec);
      chk("res_row", res_row, er);
      chk("res_col", res_col, ec);
      chk("res_data", res_data, (m_phase == 3) ? cexp(er, ec) : 16'h0);
    end
  end

  logic [15:0] rd [$];
  int          rr [$];
  int          rc [$];

  task automatic chk_zero(input string name);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_done"}, done, 0);
    chk({name, "_arr_clr"}, arr_clr, 0);
    chk({name, "_r_en"}, r_en, 0);
    chk({name, "_c_en"}, c_en, 0);
    for (int i = 0; i < S; i++) begin
      chk({name, "_l_x_out"}, l_x_out[i], 0);
      chk({name, "_t_w_out"}, t_w_out[i], 0);
    end
    chk({name, "_s_row"}, s_row, 0);
    chk({name, "_s_col"}, s_col, 0);
    chk({name, "_res_valid"}, res_valid, 0);
    chk({name, "_res_data"}, res_data, 0);
    chk({name, "_res_row"}, res_row, 0);
    chk({name, "_res_col"}, res_col, 0);
  endtask

  task automatic load(input logic sel, input int row, input int col, input logic [15:0] data);
    @(negedge clk);
    ld_en   = 1'b1;
    ld_sel  = sel;
    ld_row  = 2'(row);
    ld_col  = 2'(col);
    ld_data = data;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic run_job(input int stall, input bit skew, input bit lock, input int rst_at,
                         input bit sl, input int sl_row, input int sl_col, input logic [15:0] sl_data,
                         output int first_v, output int done_at);
    int stall_left;
    stall_left = stall;
    first_v = -1;
    done_at = -1;
    rd.delete(); rr.delete(); rc.delete();
    @(negedge clk);
    start = 1'b1;
    res_ready = 1'b1;
    if (sl) begin
      ld_en = 1'b1; ld_sel = 1'b1; ld_row = 2'(sl_row); ld_col = 2'(sl_col); ld_data = sl_data;
    end
    for (int k = 1; k <= 80; k++) begin
      @(negedge clk);
      start = 1'b0;
      ld_en = 1'b0;
      if (res_valid && first_v < 0) first_v = k;
      if (done) begin done_at = k; break; end
      if (skew && k == 4) begin
        chk("skew_t2_lane0", l_x_out[0], 16'h02);
        chk("skew_t2_lane1", l_x_out[1], 16'h11);
        chk("skew_t2_lane2", l_x_out[2], 16'h20);
      end
      if (skew && k == 7) begin
        chk("skew_t5_lane0", l_x_out[0], 16'h0);
        chk("skew_t5_lane1", l_x_out[1], 16'h0);
        chk("skew_t5_lane2", l_x_out[2], 16'h0);
      end
      if (lock && k == 5) begin
        ld_en = 1'b1; ld_sel = 1'b0; ld_row = 2'd0; ld_col = 2'd0; ld_data = 16'hBEEF;
        start = 1'b1;
      end
      if (rst_at > 0 && k == rst_at) reset = 1'b1;
      if (rst_at > 0 && k == rst_at + 1) begin
        chk_zero("rst_mid");
        reset = 1'b0;
      end
      if (rst_at > 0 && k == rst_at + 40) break;
      if (stall_left > 0 && res_valid && res_row == 2'd1 && res_col == 2'd1) begin
        res_ready = 1'b0;
        stall_left--;
      end else begin
        res_ready = 1'b1;
      end
      if (res_valid && res_ready) begin
        rd.push_back(res_data);
        rr.push_back(int'(res_row));
        rc.push_back(int'(res_col));
      end
    end
    if (rst_at > 0) chk("no_done_after_reset", done_at < 0, 1);
    else if (done_at < 0) chk("done_timeout", 0, 1);
  endtask

  task automatic check_res(input string name, input logic [15:0] e [S*S]);
    chk({name, "_count"}, rd.size(), S * S);
    for (int q = 0; q < S * S && q < rd.size(); q++) begin
      chk({name, "_row"}, rr[q], q / S);
      chk({name, "_col"}, rc[q], q % S);
      chk({name, "_data"}, rd[q], e[q]);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] e_w [S*S];
    logic [15:0] e_z [S*S];
    logic [15:0] e_s [S*S];
    int fv, da;

    reset = 1'b1; ld_en = 1'b0; ld_sel = 1'b0; start = 1'b0; res_ready = 1'b1;
    ld_row = '0; ld_col = '0; ld_data = '0;
    for (int q = 0; q < S * S; q++) begin
      e_w[q] = 16'((q + 1) * 16'h0100);
      e_z[q] = 16'h0;
      e_s[q] = (q == 7) ? 16'h0700 : 16'h0;
    end
    repeat (2) @(negedge clk);
    cmp_on = 1'b1;
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    // Skew pattern through the X edge with W all zero.
    for (int i = 0; i < S; i++)
      for (int k = 0; k < S; k++) load(1'b0, i, k, 16'(16'h10 * i + k));
    run_job(0, 1, 0, 0, 0, 0, 0, 16'h0, fv, da);
    check_res("skew", e_z);

    // Identity X: results reproduce W.
    for (int i = 0; i < S; i++)
      for (int j = 0; j < S; j++) begin
        load(1'b0, i, j, (i == j) ? 16'h0100 : 16'h0);
        load(1'b1, i, j, 16'((3 * i + j + 1) * 16'h0100));
      end
    run_job(0, 0, 0, 0, 0, 0, 0, 16'h0, fv, da);
    chk("ident_first_valid", fv, 9);
    chk("ident_done_cycle", da, 18);
    check_res("ident", e_w);

    run_job(4, 0, 0, 0, 0, 0, 0, 16'h0, fv, da);
    chk("bp_first_valid", fv, 9);
    chk("bp_done_cycle", da, 22);
    check_res("bp", e_w);

    run_job(0, 0, 1, 0, 0, 0, 0, 16'h0, fv, da);
    chk("lock_done_cycle", da, 18);
    check_res("lock", e_w);
    repeat (5) @(negedge clk);
    chk("lock_no_second_job", busy, 0);
    run_job(0, 0, 0, 0, 0, 0, 0, 16'h0, fv, da);
    chk("rerun_done_cycle", da, 18);
    check_res("rerun", e_w);

    // Reset at FEED step 3, then a job over the cleared buffers.
    run_job(0, 0, 0, 5, 0, 0, 0, 16'h0, fv, da);
    run_job(0, 0, 0, 0, 0, 0, 0, 16'h0, fv, da);
    chk("zero_done_cycle", da, 18);
    check_res("zero", e_z);

    for (int i = 0; i < S; i++) load(1'b0, i, i, 16'h0100);
    run_job(0, 0, 0, 0, 1, 2, 1, 16'h0700, fv, da);
    chk("same_cycle_done_cycle", da, 18);
    check_res("same_cycle", e_s);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
